// File: rtl/cache_arbiter.sv
// -----------------------------------------------------------------------------
// cache_arbiter
//   Shares the single physical-memory line port between the I-cache and the
//   D-cache miss handlers. One line transaction (I read, D read or D
//   writeback) is in flight at a time. Each requester sees a single-cycle
//   completion pulse that the pipeline stall logic waits on.
//
// Optional feature macro: ARB_STARVE_GUARD_EN
//   Defined   : after STARVE_LIMIT consecutive D grants made while i_read is
//               pending, the next IDLE arbitration goes to I regardless of D.
//   Undefined : strict D-over-I priority, no starvation counter.
//
// Ports
//   clk, rst                  clock (rising edge), async active-low reset
//   i_read, i_addr            I-cache line read request / line address
//   i_rdata, i_resp           line to I-cache, 1-cycle completion pulse
//   d_read, d_write, d_addr   D-cache line read / writeback request, address
//   d_wdata                   D-cache writeback line
//   d_rdata, d_resp           line to D-cache, 1-cycle completion pulse
//   mem_read, mem_write       memory command, held until mem_resp
//   mem_addr, mem_wdata       memory address / write line
//   mem_rdata, mem_resp       memory read line / completion
// -----------------------------------------------------------------------------

// Protocol checker kept apart from the datapath; bound in by the top module.
module cache_arbiter_checker #(
  parameter int STARVE_LIMIT = 4
) (
  input logic        i_clk,
  input logic        i_rst,
  input logic        i_d_read,
  input logic        i_d_write,
  input logic        i_mem_resp,
  input logic        i_serving,
  input logic        i_mem_read,
  input logic        i_mem_write,
  input logic        i_i_resp,
  input logic        i_d_resp,
  input logic [31:0] i_starve_cnt
);

  a_no_rd_wr_both : assert property (@(posedge i_clk) disable iff (!i_rst)
    !(i_d_read && i_d_write));

  a_resp_only_serving : assert property (@(posedge i_clk) disable iff (!i_rst)
    i_mem_resp |-> i_serving);

  a_one_mem_cmd : assert property (@(posedge i_clk) disable iff (!i_rst)
    !(i_mem_read && i_mem_write));

  a_one_resp : assert property (@(posedge i_clk) disable iff (!i_rst)
    !(i_i_resp && i_d_resp));

  a_starve_bound : assert property (@(posedge i_clk) disable iff (!i_rst)
    i_starve_cnt <= 32'(STARVE_LIMIT));

endmodule

module cache_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int LINE_WIDTH   = 256,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_SERVE_I = 2'd1;
  localparam logic [1:0] ST_SERVE_D = 2'd2;
  localparam logic [1:0] ST_RECOVER = 2'd3;

  logic [1:0]            r_state;
  logic [1:0]            w_state_nxt;
  logic                  w_d_req;
  logic                  w_grant_d;
  logic                  w_grant_i;
  logic                  w_serving;
  logic                  w_starve_hit;
  logic [31:0]           w_starve_cnt_ext;

  // The memory command registers double as the latched transaction.
  logic                  r_mem_read;
  logic                  r_mem_write;
  logic [ADDR_WIDTH-1:0] r_mem_addr;
  logic [LINE_WIDTH-1:0] r_mem_wdata;

  assign w_d_req   = d_read | d_write;
  assign w_serving = (r_state == ST_SERVE_I) || (r_state == ST_SERVE_D);

`ifdef ARB_STARVE_GUARD_EN
  localparam int CNT_W = ($clog2(STARVE_LIMIT + 1) < 1) ? 1 : $clog2(STARVE_LIMIT + 1);

  logic [CNT_W-1:0] r_starve_cnt;

  assign w_starve_hit     = i_read && (r_starve_cnt >= CNT_W'(STARVE_LIMIT));
  assign w_starve_cnt_ext = 32'(r_starve_cnt);

  // Starvation counter: counts D grants that overtook a waiting I request.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_starve_cnt <= '0;
    end else if (w_grant_i) begin
      r_starve_cnt <= '0;
    end else if (w_grant_d && i_read && (r_starve_cnt < CNT_W'(STARVE_LIMIT))) begin
      r_starve_cnt <= r_starve_cnt + CNT_W'(1);
    end else begin
      r_starve_cnt <= r_starve_cnt;
    end
  end
`else
  assign w_starve_hit     = 1'b0;
  assign w_starve_cnt_ext = 32'd0;
`endif

  // IDLE arbitration: starvation override, then D, then I.
  always_comb begin
    w_grant_d = 1'b0;
    w_grant_i = 1'b0;
    if (r_state == ST_IDLE) begin
      if (w_starve_hit) begin
        w_grant_i = 1'b1;
      end else if (w_d_req) begin
        w_grant_d = 1'b1;
      end else if (i_read) begin
        w_grant_i = 1'b1;
      end else begin
        w_grant_i = 1'b0;
      end
    end else begin
      w_grant_d = 1'b0;
    end
  end

  // Next-state logic; RECOVER is a fixed one-cycle bubble so a requester
  // can drop its level request before IDLE samples it again.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant_d) begin
          w_state_nxt = ST_SERVE_D;
        end else if (w_grant_i) begin
          w_state_nxt = ST_SERVE_I;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SERVE_I, ST_SERVE_D: begin
        if (mem_resp) begin
          w_state_nxt = ST_RECOVER;
        end else begin
          w_state_nxt = r_state;
        end
      end
      ST_RECOVER: w_state_nxt = ST_IDLE;
      default:    w_state_nxt = ST_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Memory command registers: loaded on grant, cleared after the mem_resp
  // cycle. Both D strobes high is treated as a writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else if (w_grant_d) begin
      r_mem_read  <= ~d_write;
      r_mem_write <= d_write;
      r_mem_addr  <= d_addr;
      r_mem_wdata <= d_write ? d_wdata : '0;
    end else if (w_grant_i) begin
      r_mem_read  <= 1'b1;
      r_mem_write <= 1'b0;
      r_mem_addr  <= i_addr;
      r_mem_wdata <= '0;
    end else if (w_serving && mem_resp) begin
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_mem_read  <= r_mem_read;
      r_mem_write <= r_mem_write;
      r_mem_addr  <= r_mem_addr;
      r_mem_wdata <= r_mem_wdata;
    end
  end

  assign mem_read  = r_mem_read;
  assign mem_write = r_mem_write;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;

  // Responses are combinational from mem_resp so the stall releases in the
  // same cycle the line arrives; data is forced to zero outside the pulse.
  assign i_resp  = (r_state == ST_SERVE_I) && mem_resp;
  assign d_resp  = (r_state == ST_SERVE_D) && mem_resp;
  assign i_rdata = i_resp ? mem_rdata : '0;
  assign d_rdata = d_resp ? mem_rdata : '0;

  cache_arbiter_checker #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_checker (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_d_read     (d_read),
    .i_d_write    (d_write),
    .i_mem_resp   (mem_resp),
    .i_serving    (w_serving),
    .i_mem_read   (r_mem_read),
    .i_mem_write  (r_mem_write),
    .i_i_resp     (i_resp),
    .i_d_resp     (d_resp),
    .i_starve_cnt (w_starve_cnt_ext)
  );

endmodule

// File: tb/tb_cache_arbiter.sv
// -----------------------------------------------------------------------------
// tb_cache_arbiter
//   Transaction-level bench for cache_arbiter. A memory responder returns a
//   line derived from the address after a chosen or random latency; each
//   scenario predicts grant order, command contents, response timing and
//   returned data from the arbitration rules.
// -----------------------------------------------------------------------------
module tb_cache_arbiter;

  localparam int AW    = 32;
  localparam int LW    = 256;
  localparam int LIMIT = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  int n_vec  = 0;
  int n_miss = 0;
  int mem_lat = -1;   // -1: responder picks a random latency

  cache_arbiter #(
    .ADDR_WIDTH(AW), .LINE_WIDTH(LW), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Memory contents as seen by the arbiter: a fixed function of the address.
  function automatic logic [LW-1:0] mem_line(input logic [AW-1:0] a);
    if (a == 32'h0000_1040) return {32{8'hA5}};
    return {8{a ^ 32'h5A5A_C3C3}};
  endfunction

  // Memory responder: mem_resp arrives `lat` cycles after the command first
  // appears (0 = same cycle).
  initial begin : mem_responder
    int cnt;
    cnt = -1;
    mem_resp = 1'b0;
    mem_rdata = '0;
    forever begin
      @(posedge clk);
      #1;
      mem_resp = 1'b0;
      mem_rdata = '0;
      if (mem_read || mem_write) begin
        if (cnt == -1) cnt = (mem_lat >= 0) ? mem_lat : int'($urandom_range(0, 5));
        if (cnt == 0) begin
          mem_resp = 1'b1;
          mem_rdata = mem_line(mem_addr);
          cnt = -2;
        end else if (cnt > 0) begin
          cnt--;
        end
      end else begin
        cnt = -1;
      end
    end
  end

  // Always-true properties checked every cycle.
  initial begin : monitor
    forever begin
      @(negedge clk);
      if (!i_resp) check("i_rdata_quiet", i_rdata, '0);
      if (!d_resp) check("d_rdata_quiet", d_rdata, '0);
      if (mem_read) check("single_mem_cmd", mem_write, 1'b0);
      if (i_resp) check("single_resp", d_resp, 1'b0);
    end
  end

  // One granted access: `gap` idle samples, then the active command until
  // mem_resp, then the requester drops its request.
  task automatic serve(input bit is_d, input bit is_w, input logic [AW-1:0] a,
                       input logic [LW-1:0] wd, input int gap, output int ncyc);
    bit done;
    for (int k = 0; k < gap; k++) begin
      @(negedge clk);
      check("gap_no_cmd", {mem_read, mem_write}, 2'b00);
      check("gap_no_resp", {i_resp, d_resp}, 2'b00);
    end
    done = 1'b0;
    ncyc = 0;
    while (!done && ncyc < 64) begin
      @(negedge clk);
      ncyc++;
      check("mem_read", mem_read, !is_w);
      check("mem_write", mem_write, is_w);
      check("mem_addr", mem_addr, a);
      if (is_w) check("mem_wdata", mem_wdata, wd);
      if (mem_resp) begin
        done = 1'b1;
        check("resp_owner", {i_resp, d_resp}, is_d ? 2'b01 : 2'b10);
        check("rdata", is_d ? d_rdata : i_rdata, mem_line(a));
      end else begin
        check("resp_early", {i_resp, d_resp}, 2'b00);
      end
    end
    if (!done) check("resp_timeout", 1'b0, 1'b1);
    @(posedge clk);
    #1;
    if (is_d) begin
      d_read = 1'b0;
      d_write = 1'b0;
    end else begin
      i_read = 1'b0;
    end
  endtask

  // Raise requests together; D (if any) is served first, then I after the
  // two-cycle RECOVER + IDLE spacing.
  task automatic scenario(input bit do_i, input int d_op, input logic [AW-1:0] ia,
                          input logic [AW-1:0] da, input logic [LW-1:0] wd, output int n_first);
    int n2;
    @(posedge clk);
    #1;
    i_addr = ia;
    d_addr = da;
    d_wdata = wd;
    i_read = do_i;
    d_read = (d_op == 1);
    d_write = (d_op == 2);
    if (d_op != 0) begin
      serve(1'b1, d_op == 2, da, wd, 1, n_first);
      if (do_i) serve(1'b0, 1'b0, ia, '0, 2, n2);
    end else begin
      serve(1'b0, 1'b0, ia, '0, 1, n_first);
    end
    @(negedge clk);
    check("recover_quiet", {mem_read, mem_write, i_resp, d_resp}, 4'b0000);
  endtask

  // Both requesters held high; expected grant order comes from the
  // starvation rule applied to a simple count of overtaking D grants.
  task automatic starve_test();
    logic [AW-1:0] ia;
    logic [AW-1:0] da;
    int  cnt;
    bit  exp_i;
    bit  seen;
    ia = 32'h0000_3000;
    da = 32'h0000_4000;
    cnt = 0;
    @(posedge clk);
    #1;
    i_addr = ia;
    d_addr = da;
    i_read = 1'b1;
    d_read = 1'b1;
    d_write = 1'b0;
    for (int g = 0; g < 6; g++) begin
      exp_i = 1'b0;
`ifdef ARB_STARVE_GUARD_EN
      exp_i = (cnt >= LIMIT);
`endif
      seen = 1'b0;
      for (int k = 0; k < 8 && !seen; k++) begin
        @(negedge clk);
        seen = mem_read;
      end
      check("starve_grant_seen", seen, 1'b1);
      check("starve_grant_who", mem_addr, exp_i ? ia : da);
      seen = mem_resp;
      for (int k = 0; k < 16 && !seen; k++) begin
        @(negedge clk);
        seen = mem_resp;
      end
      check("starve_resp_seen", seen, 1'b1);
      check("starve_resp_who", {i_resp, d_resp}, exp_i ? 2'b10 : 2'b01);
      if (exp_i) cnt = 0;
      else if (cnt < LIMIT) cnt++;
    end
    @(posedge clk);
    #1;
    i_read = 1'b0;
    d_read = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("starve_drain_quiet", {mem_read, mem_write}, 2'b00);
    end
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int n;
    int d_op;
    bit do_i;
    logic [AW-1:0] ra;
    logic [AW-1:0] rb;
    logic [LW-1:0] rw;

    rst = 1'b0;
    i_read = 1'b0; i_addr = '0;
    d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0;
    repeat (2) @(negedge clk);
    check("reset_cmd", {mem_read, mem_write, i_resp, d_resp}, 4'b0000);
    check("reset_addr", mem_addr, '0);
    check("reset_wdata", mem_wdata, '0);
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Single I read, 5-cycle memory latency: six active cycles.
    mem_lat = 5;
    scenario(1'b1, 0, 32'h0000_1040, '0, '0, n);
    check("i_read_active_cycles", n, 6);

    // Simultaneous D read and I read.
    mem_lat = -1;
    scenario(1'b1, 1, 32'h0000_5000, 32'h0000_6020, '0, n);

    // D writeback with a fixed pattern.
    scenario(1'b0, 2, '0, 32'h0000_2000, {8{32'h1234_5678}}, n);

    // Randomised mix of requests, addresses, data and latencies.
    for (int s = 0; s < 40; s++) begin
      do_i = 1'($urandom_range(0, 1));
      d_op = int'($urandom_range(0, 2));
      if (!do_i && d_op == 0) do_i = 1'b1;
      ra = $urandom() & 32'hFFFF_FFE0;
      rb = $urandom() & 32'hFFFF_FFE0;
      rw = {$urandom(), $urandom(), $urandom(), $urandom(),
            $urandom(), $urandom(), $urandom(), $urandom()};
      scenario(do_i, d_op, ra, rb, rw, n);
    end

    starve_test();

    // Reset in the middle of a 10-cycle writeback.
    mem_lat = 10;
    @(posedge clk);
    #1;
    d_addr = 32'h0000_7000;
    d_wdata = {8{32'hDEAD_BEEF}};
    d_write = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("wb_before_reset", mem_write, 1'b1);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    d_write = 1'b0;
    @(negedge clk);
    check("midreset_ctl", {mem_read, mem_write, i_resp, d_resp}, 4'b0000);
    check("midreset_addr", mem_addr, '0);
    check("midreset_wdata", mem_wdata, '0);
    check("midreset_rdata", {i_rdata, d_rdata} == '0, 1'b1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("post_reset_idle", {mem_read, mem_write, d_resp}, 3'b000);
    end
    mem_lat = -1;

    // Normal service resumes after the abandoned transaction.
    scenario(1'b1, 2, 32'h0000_8000, 32'h0000_9000, {8{32'h0F0F_F0F0}}, n);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
